// File: rtl/pipeline_stall_ctrl_pkg.sv
// pipeline_stall_ctrl_pkg: shared pipeline control constants and FSM encodings.
package pipeline_stall_ctrl_pkg;
  localparam int NB_COUNT_DEF = 32;
  localparam int DRAIN_CYCLES_DEF = 3;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
endpackage

// File: rtl/event_counter.sv
// event_counter: wrapping event counter with enable and synchronous clear.
module event_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);
  always_ff @(posedge clk)
    if (clr) count <= '0;
    else if (en) count <= count + 1'b1;
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: PC/IF-ID enables, flush/bubble control and halt drain FSM.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int NB_COUNT = NB_COUNT_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_valid,
  input  logic                i_hazard,
  input  logic                i_branch_taken,
  input  logic                i_halt_id,
  output logic                o_pc_we,
  output logic                o_ifid_we,
  output logic                o_ifid_flush,
  output logic                o_idex_bubble,
  output logic                o_halted,
  output logic [NB_COUNT-1:0] o_stall_count,
  output logic [NB_COUNT-1:0] o_flush_count
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1) < 1 ? 1 : $clog2(DRAIN_CYCLES + 1);
  state_t state;
  logic [DW-1:0] drain;
  logic run_v, advance;
  // Reset masks the enables so the pipeline sees RUN with no advance.
  assign run_v = i_valid && !i_reset && state == RUN;
  assign advance = run_v && !i_hazard && !i_halt_id;
  assign o_pc_we = advance;
  assign o_ifid_we = advance;
  assign o_ifid_flush = advance && i_branch_taken;
  assign o_idex_bubble = run_v && i_hazard;
  assign o_halted = state == HALTED;
  always_ff @(posedge i_clock)
    if (i_reset) begin
      state <= RUN;
      drain <= '0;
    end else if (i_valid) begin
      if (state == RUN && !i_hazard && i_halt_id) begin
        state <= DRAIN;
        drain <= DW'(DRAIN_CYCLES);
      end else if (state == DRAIN) begin
        drain <= drain - 1'b1;
        state <= drain <= DW'(1) ? HALTED : DRAIN;
      end
    end
  event_counter #(.W(NB_COUNT)) u_stall (
    .clk(i_clock), .clr(i_reset), .en(o_idex_bubble), .count(o_stall_count)
  );
  event_counter #(.W(NB_COUNT)) u_flush (
    .clk(i_clock), .clr(i_reset), .en(o_ifid_flush), .count(o_flush_count)
  );
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed scenario checks of the stall/flush/halt controller.
module tb_pipeline_stall_ctrl;
  localparam int NB = 4;
  logic clk = 0, rst = 1, valid = 0, hazard = 0, branch = 0, halt = 0;
  logic pc_we, ifid_we, ifid_flush, idex_bubble, halted;
  logic [NB-1:0] stall_count, flush_count;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  pipeline_stall_ctrl #(.NB_COUNT(NB), .DRAIN_CYCLES(3)) dut (
    .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_hazard(hazard),
    .i_branch_taken(branch), .i_halt_id(halt), .o_pc_we(pc_we), .o_ifid_we(ifid_we),
    .o_ifid_flush(ifid_flush), .o_idex_bubble(idex_bubble), .o_halted(halted),
    .o_stall_count(stall_count), .o_flush_count(flush_count)
  );
  task automatic drive(input logic v, input logic h, input logic b, input logic hl);
    valid = v; hazard = h; branch = b; halt = hl;
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1;
    drive(0, 0, 0, 0);
    tick();
    rst = 0;
  endtask
  task automatic test_reset();
    rst = 1;
    drive(1, 1, 1, 1);
    checks++;
    if ({pc_we, ifid_we, ifid_flush, idex_bubble} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=0000", {pc_we, ifid_we, ifid_flush, idex_bubble});
    end
    tick();
    rst = 0;
    drive(0, 0, 0, 0);
    checks++;
    if ({halted, stall_count, flush_count} !== '0) begin
      errors++; $display("FAIL reset_state halted=%b stall=%0d flush=%0d exp=0/0/0", halted, stall_count, flush_count);
    end
  endtask
  task automatic test_stall();
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, 0);
      checks++;
      if ({pc_we, ifid_we, ifid_flush, idex_bubble} !== 4'b0001) begin
        errors++; $display("FAIL stall_ctrl cyc=%0d got=%b exp=0001", i, {pc_we, ifid_we, ifid_flush, idex_bubble});
      end
      tick();
    end
    drive(0, 0, 0, 0);
    checks++;
    if (stall_count !== 4'd2) begin
      errors++; $display("FAIL stall_count got=%0d exp=2", stall_count);
    end
  endtask
  task automatic test_priority();
    drive(1, 1, 1, 1);
    checks++;
    if ({pc_we, ifid_we, ifid_flush, idex_bubble} !== 4'b0001) begin
      errors++; $display("FAIL prio_ctrl got=%b exp=0001", {pc_we, ifid_we, ifid_flush, idex_bubble});
    end
    tick();
    drive(1, 0, 0, 0);
    checks++;
    if ({stall_count, flush_count} !== {4'd3, 4'd0}) begin
      errors++; $display("FAIL prio_counts stall=%0d flush=%0d exp=3/0", stall_count, flush_count);
    end
    checks++;
    if ({pc_we, ifid_we, ifid_flush, idex_bubble, halted} !== 5'b11000) begin
      errors++; $display("FAIL prio_still_run got=%b exp=11000", {pc_we, ifid_we, ifid_flush, idex_bubble, halted});
    end
    tick();
  endtask
  task automatic test_branch();
    drive(1, 0, 1, 0);
    checks++;
    if ({pc_we, ifid_we, ifid_flush, idex_bubble} !== 4'b1110) begin
      errors++; $display("FAIL branch_ctrl got=%b exp=1110", {pc_we, ifid_we, ifid_flush, idex_bubble});
    end
    tick();
    drive(0, 0, 1, 0);
    checks++;
    if ({pc_we, ifid_we, ifid_flush, idex_bubble} !== 4'b0000) begin
      errors++; $display("FAIL invalid_ctrl got=%b exp=0000", {pc_we, ifid_we, ifid_flush, idex_bubble});
    end
    tick();
    checks++;
    if ({stall_count, flush_count} !== {4'd3, 4'd1}) begin
      errors++; $display("FAIL branch_counts stall=%0d flush=%0d exp=3/1", stall_count, flush_count);
    end
  endtask
  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1, 1, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0);
    checks++;
    if (stall_count !== 4'd1) begin
      errors++; $display("FAIL stall_wrap got=%0d exp=1", stall_count);
    end
  endtask
  task automatic test_halt();
    logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    drive(1, 0, 1, 1);
    checks++;
    if ({pc_we, ifid_we, ifid_flush, idex_bubble} !== 4'b0000) begin
      errors++; $display("FAIL halt_ctrl got=%b exp=0000", {pc_we, ifid_we, ifid_flush, idex_bubble});
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(pat[i], 1, 1, 0);
      checks++;
      if ({pc_we, ifid_we, ifid_flush, idex_bubble, halted} !== 5'b00000) begin
        errors++; $display("FAIL drain_ctrl cyc=%0d got=%b exp=00000", i, {pc_we, ifid_we, ifid_flush, idex_bubble, halted});
      end
      tick();
    end
    drive(1, 1, 1, 1);
    checks++;
    if ({pc_we, ifid_we, ifid_flush, idex_bubble, halted} !== 5'b00001) begin
      errors++; $display("FAIL halted_ctrl got=%b exp=00001", {pc_we, ifid_we, ifid_flush, idex_bubble, halted});
    end
    tick();
    checks++;
    if ({halted, stall_count, flush_count} !== {1'b1, 4'd0, 4'd0}) begin
      errors++; $display("FAIL halted_hold halted=%b stall=%0d flush=%0d exp=1/0/0", halted, stall_count, flush_count);
    end
  endtask
  task automatic test_reset_halted();
    rst = 1;
    drive(1, 0, 0, 0);
    tick();
    rst = 0;
    drive(1, 0, 0, 0);
    checks++;
    if ({halted, stall_count, flush_count, pc_we} !== {1'b0, 4'd0, 4'd0, 1'b1}) begin
      errors++; $display("FAIL reset_from_halted halted=%b stall=%0d flush=%0d pc_we=%b exp=0/0/0/1", halted, stall_count, flush_count, pc_we);
    end
    tick();
  endtask
  initial begin
    test_reset();
    test_stall();
    test_priority();
    test_branch();
    test_wrap();
    test_halt();
    test_reset_halted();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
